// File: rtl/isp_pkg.sv
// isp_pkg: shared ISP definitions for colour codes, gain constants and AWB controller states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isp_pkg;

  // Channel codes carried on the pixel tap; code 3 is a don't-care pixel.
  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  // Gains are Q8.8; the WB stage only consumes bits [11:4], so 0x0FFF is the top usable value.
  localparam logic [15:0] GAIN_UNITY = 16'h0100;
  localparam logic [15:0] GAIN_MAX   = 16'h0FFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    DIV_R,
    LOAD_B,
    DIV_B,
    UPDATE
  } awb_state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: start is sampled on an edge, the next W edges each retire one bit; done is high
//          in the cycle whose closing edge retires the last bit, quotient is valid after it.
// Backpressure: none; a start while running restarts with the new operands.
// Ports: clk/rst (sync, active-high); start/dividend/divisor load a division;
//        done, quotient, div_by_zero (divisor of the latest start was zero).
module seq_divider #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;   // dividend shifts out of the top while quotient bits shift in
  logic [W-1:0]  den;
  logic [CW-1:0] cnt;   // bits still to retire; zero when idle
  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  diff;

  // Partial remainder is always < den, so the trial difference fits in W bits.
  always_comb begin
    shifted = {rem, quo[W-1]};
    ge      = shifted >= {1'b0, den};
    diff    = shifted[W-1:0] - den;
  end

  assign done     = (cnt == CW'(1));
  assign quotient = quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      quo         <= '0;
      den         <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      rem         <= '0;
      quo         <= dividend;
      den         <= divisor;
      cnt         <= CW'(W);
      div_by_zero <= (divisor == '0);
    end else if (cnt != '0) begin
      rem <= ge ? diff : shifted[W-1:0];
      quo <= {quo[W-2:0], ge};
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/wb_gain_ctrl.sv
// wb_gain_ctrl: gray-world AWB; accumulates R/G/B sums per frame and derives Q8.8 R/B gains vs G.
// Latency: gains update on edge E0 + 2*NUM_W + 3 after the accepted last pixel (edge E0).
// Backpressure: none; the pixel tap is never stalled, a frame end arriving while busy is
//               dropped (sums cleared) and flagged by a one-cycle ovf_o pulse.
// Ports: clk/rst (sync, active-high); awb_en_i, valid_i, color_i, value_i, last_i pixel tap;
//        K_R/K_G/K_B gains, valid_gain_o, busy_o, ovf_o status.
module wb_gain_ctrl
  import isp_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int G_RATIO_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awb_en_i,
  input  logic        valid_i,
  input  logic [1:0]  color_i,
  input  logic [7:0]  value_i,
  input  logic        last_i,
  output logic [15:0] K_R,
  output logic [15:0] K_G,
  output logic [15:0] K_B,
  output logic        valid_gain_o,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int SUM_W = CNT_W + 8;
  localparam int NUM_W = SUM_W + 8;

  awb_state_t       state;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [SUM_W-1:0] add_r, add_g, add_b;
  logic [SUM_W-1:0] snap_r, snap_g, snap_b;
  logic [15:0]      gain_r_hold;   // red result parked here so both gains land together
  logic             accept;
  logic             frame_end;

  logic             div_start;
  logic [NUM_W-1:0] div_num, div_den, div_q;
  logic             div_done, div_dbz;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s, input logic [7:0] v);
    logic [SUM_W:0] t;
    t = {1'b0, s} + (SUM_W + 1)'(v);
    return t[SUM_W] ? '1 : t[SUM_W-1:0];
  endfunction

  function automatic logic [15:0] to_gain(input logic [NUM_W-1:0] q, input logic dbz);
    if (dbz)                      return GAIN_UNITY;
    else if (q > NUM_W'(GAIN_MAX)) return GAIN_MAX;
    else                          return q[15:0];
  endfunction

  assign accept    = valid_i & awb_en_i;
  assign frame_end = accept & last_i;

  // Next accumulator values including this cycle's pixel; they hold when nothing is accepted.
  always_comb begin
    add_r = sum_r;
    add_g = sum_g;
    add_b = sum_b;
    if (accept) begin
      case (color_i)
        RED:     add_r = sat_add(sum_r, value_i);
        GREEN:   add_g = sat_add(sum_g, value_i);
        BLUE:    add_b = sat_add(sum_b, value_i);
        default: ;
      endcase
    end
  end

  // Single divider: operands are selected by which LOAD state is issuing the start.
  // Green is pre-scaled by 2^8 for Q8.8 and by 1/2^G_RATIO_LOG2 for the extra green samples.
  assign div_start = (state == LOAD_R) || (state == LOAD_B);
  assign div_num   = {{8{1'b0}}, snap_g} << (8 - G_RATIO_LOG2);
  assign div_den   = (state == LOAD_B) ? {{8{1'b0}}, snap_b} : {{8{1'b0}}, snap_r};

  seq_divider #(.W(NUM_W)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (div_num),
    .divisor     (div_den),
    .done        (div_done),
    .quotient    (div_q),
    .div_by_zero (div_dbz)
  );

  assign K_G    = GAIN_UNITY;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sum_r        <= '0;
      sum_g        <= '0;
      sum_b        <= '0;
      snap_r       <= '0;
      snap_g       <= '0;
      snap_b       <= '0;
      gain_r_hold  <= GAIN_UNITY;
      K_R          <= GAIN_UNITY;
      K_B          <= GAIN_UNITY;
      valid_gain_o <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      ovf_o <= 1'b0;

      // A frame end always restarts accumulation; its sums are kept only if the FSM is free.
      if (frame_end) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
        if (state == IDLE) begin
          snap_r <= add_r;
          snap_g <= add_g;
          snap_b <= add_b;
        end else begin
          ovf_o <= 1'b1;
        end
      end else begin
        sum_r <= add_r;
        sum_g <= add_g;
        sum_b <= add_b;
      end

      case (state)
        IDLE:   if (frame_end) state <= LOAD_R;
        LOAD_R: state <= DIV_R;
        DIV_R:  if (div_done) state <= LOAD_B;
        LOAD_B: begin
          // Divider still holds the red result; the new start only takes effect at this edge.
          gain_r_hold <= to_gain(div_q, div_dbz);
          state       <= DIV_B;
        end
        DIV_B:  if (div_done) state <= UPDATE;
        UPDATE: begin
          K_R          <= gain_r_hold;
          K_B          <= to_gain(div_q, div_dbz);
          valid_gain_o <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
